interrupt_acknowledge_decoder: RTL and testbench

- Counterpart of the 16-input interrupt priority encoder.
- The CPU side hands over the encoded index of the interrupt it has taken.
- The block decodes the index to a one-hot acknowledge line and holds it until the device drops its request, with a timeout guard.
- Sits between the CPU interrupt logic and the 16 device request/acknowledge pairs.

---
 rtl/interrupt_acknowledge_decoder.sv | 154 +++++++++++++++
 tb/tb_interrupt_acknowledge_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/interrupt_acknowledge_decoder.sv
// Interrupt acknowledge decoder.
// Takes the encoded index of the interrupt the CPU has taken and drives a
// registered one-hot acknowledge to that device. The acknowledge is held
// until the device drops its request, or until a timeout expires. Every
// acknowledge is followed by one RELEASE cycle, so consecutive acknowledges,
// including two to the same device, are always separated by a zero cycle.
//
// Optional feature (macro INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN):
//   a transfer whose request bit is already low is accepted but flagged.
//   No acknowledge is driven, the block goes straight to RELEASE, and
//   spuriousError pulses for that RELEASE cycle.
//
// Ports:
//   clk               - system clock, rising edge
//   reset_n           - asynchronous active-low reset
//   ackValid          - CPU presents an index to acknowledge
//   ackIndex          - encoded interrupt index 0..15
//   ackReady          - combinational; high only in IDLE and out of reset
//   interruptRequests - level request lines, bit i = device i
//   acknowledgeLines  - registered one-hot acknowledge lines
//   busy              - registered; high in any state other than IDLE
//   timeoutError      - registered one-cycle pulse on acknowledge timeout
//   spuriousError     - (macro only) one-cycle pulse on a spurious transfer
module interrupt_acknowledge_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned COUNTER_WIDTH  = 8,
  localparam int unsigned NUM_LINES     = 16,
  localparam int unsigned INDEX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ackValid,
  input  logic [INDEX_WIDTH-1:0] ackIndex,
  output logic                   ackReady,
  input  logic [NUM_LINES-1:0]   interruptRequests,
  output logic [NUM_LINES-1:0]   acknowledgeLines,
  output logic                   busy,
  output logic                   timeoutError
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
  ,
  output logic                   spuriousError
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_COUNT = COUNTER_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE     = COUNTER_WIDTH'(1);
  localparam logic [NUM_LINES-1:0]     LINE_ONE      = NUM_LINES'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                   state;
  state_t                   stateNext;
  logic [INDEX_WIDTH-1:0]   latchedIndex;
  logic [INDEX_WIDTH-1:0]   indexNext;
  logic [COUNTER_WIDTH-1:0] holdCounter;
  logic [COUNTER_WIDTH-1:0] counterNext;
  logic [NUM_LINES-1:0]     ackLinesNext;
  logic                     busyNext;
  logic                     timeoutNext;
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
  logic                     spuriousNext;
`endif

  // Gated with reset_n so the CPU never sees ready while reset is held.
  assign ackReady = (state == IDLE) && reset_n;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      latchedIndex     <= '0;
      holdCounter      <= '0;
      acknowledgeLines <= '0;
      busy             <= 1'b0;
      timeoutError     <= 1'b0;
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
      spuriousError    <= 1'b0;
`endif
    end else begin
      state            <= stateNext;
      latchedIndex     <= indexNext;
      holdCounter      <= counterNext;
      acknowledgeLines <= ackLinesNext;
      busy             <= busyNext;
      timeoutError     <= timeoutNext;
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
      spuriousError    <= spuriousNext;
`endif
    end
  end

  // Next state and next registered outputs. The acknowledge is computed for
  // the cycle after the edge, so it only ever appears while in ASSERT.
  always_comb begin
    stateNext    = state;
    indexNext    = latchedIndex;
    counterNext  = holdCounter;
    ackLinesNext = '0;
    busyNext     = 1'b0;
    timeoutNext  = 1'b0;
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
    spuriousNext = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (ackValid && ackReady) begin
          indexNext   = ackIndex;
          counterNext = COUNT_ONE;
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
          if (!interruptRequests[ackIndex]) begin
            stateNext    = RELEASE;
            spuriousNext = 1'b1;
          end else begin
            stateNext    = ASSERT;
            ackLinesNext = LINE_ONE << ackIndex;
          end
`else
          stateNext    = ASSERT;
          ackLinesNext = LINE_ONE << ackIndex;
`endif
        end
      end

      ASSERT: begin
        // Release takes priority over timeout on the same edge.
        if (!interruptRequests[latchedIndex]) begin
          stateNext = RELEASE;
        end else if (holdCounter == TIMEOUT_COUNT) begin
          stateNext   = RELEASE;
          timeoutNext = 1'b1;
        end else begin
          counterNext  = holdCounter + COUNT_ONE;
          ackLinesNext = LINE_ONE << latchedIndex;
        end
      end

      RELEASE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_interrupt_acknowledge_decoder.sv
module tb_interrupt_acknowledge_decoder;

  logic        clk;
  logic        reset_n;
  logic        ackValid;
  logic [3:0]  ackIndex;
  logic        ackReady;
  logic [15:0] interruptRequests;
  logic [15:0] acknowledgeLines;
  logic        busy;
  logic        timeoutError;
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
  logic        spuriousError;
`endif

  int total;
  int bad;

  interrupt_acknowledge_decoder #(
    .TIMEOUT_CYCLES(16),
    .COUNTER_WIDTH (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ackValid         (ackValid),
    .ackIndex         (ackIndex),
    .ackReady         (ackReady),
    .interruptRequests(interruptRequests),
    .acknowledgeLines (acknowledgeLines),
    .busy             (busy),
    .timeoutError     (timeoutError)
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
    ,
    .spuriousError    (spuriousError)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs applied before the edge, outputs expected after it.
  typedef struct packed {
    logic        av;
    logic [3:0]  idx;
    logic [15:0] req;
    logic [15:0] expAck;
    logic        expReady;
    logic        expBusy;
    logic        expTimeout;
  } vec_t;

  localparam int NUM_VECS = 20;
  vec_t vecs [0:NUM_VECS-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic av, input logic [3:0] idx, input logic [15:0] req);
    ackValid          = av;
    ackIndex          = idx;
    interruptRequests = req;
    @(posedge clk);
    #1;
  endtask

  int ackCycles;

  initial begin
    total = 0;
    bad   = 0;

    // idx 5: request held three cycles
    vecs[0]  = '{1'b1, 4'd5,  16'h0020, 16'h0020, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  16'h0020, 16'h0020, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  16'h0020, 16'h0020, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    // idx 3 twice, CPU holding ackValid
    vecs[5]  = '{1'b1, 4'd3,  16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd3,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd3,  16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd3,  16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    // idx 0 with other request bits toggling and idx 9 pending
    vecs[11] = '{1'b1, 4'd0,  16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'd9,  16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'd9,  16'h0201, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'd9,  16'hFE01, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 4'd9,  16'h0200, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'd9,  16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'd9,  16'h0200, 16'h0200, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};

    reset_n           = 1'b0;
    ackValid          = 1'b0;
    ackIndex          = 4'd0;
    interruptRequests = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack",     32'(acknowledgeLines), 32'h0);
    chk("reset_busy",    32'(busy),             32'h0);
    chk("reset_ready",   32'(ackReady),         32'h0);
    chk("reset_timeout", 32'(timeoutError),     32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(ackReady), 32'h1);

    for (int i = 0; i < NUM_VECS; i++) begin
      step(vecs[i].av, vecs[i].idx, vecs[i].req);
      chk($sformatf("vec%0d_ack", i),     32'(acknowledgeLines), 32'(vecs[i].expAck));
      chk($sformatf("vec%0d_ready", i),   32'(ackReady),         32'(vecs[i].expReady));
      chk($sformatf("vec%0d_busy", i),    32'(busy),             32'(vecs[i].expBusy));
      chk($sformatf("vec%0d_timeout", i), 32'(timeoutError),     32'(vecs[i].expTimeout));
    end

    // Timeout: request 15 held forever, acknowledge lasts exactly 16 cycles.
    step(1'b1, 4'd15, 16'h8000);
    chk("to_first_ack", 32'(acknowledgeLines), 32'h8000);
    ackCycles = 1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'd0, 16'h8000);
      if (acknowledgeLines != 16'h8000) break;
      ackCycles++;
      if (timeoutError) begin
        bad++;
        total++;
        $display("FAIL to_early_pulse: timeoutError=1 expected 0 during ack at %0t", $time);
      end
    end
    chk("to_ack_cycles",     32'(ackCycles),        32'd16);
    chk("to_release_ack",    32'(acknowledgeLines), 32'h0);
    chk("to_pulse",          32'(timeoutError),     32'h1);
    chk("to_release_busy",   32'(busy),             32'h1);
    chk("to_release_ready",  32'(ackReady),         32'h0);
    step(1'b0, 4'd0, 16'h8000);
    chk("to_pulse_end",      32'(timeoutError),     32'h0);
    chk("to_idle_ready",     32'(ackReady),         32'h1);
    chk("to_idle_busy",      32'(busy),             32'h0);

    // Request already low at transfer.
    step(1'b1, 4'd7, 16'h0000);
`ifdef INTERRUPT_ACKNOWLEDGE_SPURIOUS_CHECK_EN
    chk("sp_ack",       32'(acknowledgeLines), 32'h0);
    chk("sp_pulse",     32'(spuriousError),    32'h1);
    chk("sp_busy",      32'(busy),             32'h1);
    step(1'b0, 4'd0, 16'h0000);
    chk("sp_pulse_end", 32'(spuriousError),    32'h0);
    chk("sp_idle",      32'(ackReady),         32'h1);
    chk("sp_ack2",      32'(acknowledgeLines), 32'h0);
`else
    chk("low_ack",      32'(acknowledgeLines), 32'h0080);
    chk("low_busy",     32'(busy),             32'h1);
    step(1'b0, 4'd0, 16'h0000);
    chk("low_release",  32'(acknowledgeLines), 32'h0);
    chk("low_rel_busy", 32'(busy),             32'h1);
    chk("low_timeout",  32'(timeoutError),     32'h0);
    step(1'b0, 4'd0, 16'h0000);
    chk("low_idle",     32'(ackReady),         32'h1);
`endif

    // Asynchronous reset in the middle of an acknowledge to device 10.
    step(1'b1, 4'd10, 16'h0400);
    chk("rst_ack_before", 32'(acknowledgeLines), 32'h0400);
    step(1'b0, 4'd0, 16'h0400);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ack_cleared", 32'(acknowledgeLines), 32'h0);
    chk("rst_busy",        32'(busy),             32'h0);
    chk("rst_ready_low",   32'(ackReady),         32'h0);
    chk("rst_no_timeout",  32'(timeoutError),     32'h0);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_ready_after", 32'(ackReady), 32'h1);
    step(1'b0, 4'd0, 16'h0400);
    chk("rst_stays_idle",  32'(acknowledgeLines), 32'h0);
    chk("rst_idle_busy",   32'(busy),             32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
